// File: rtl/sid_pipe_sched_pkg.sv
// Shared types and defaults for the multi-SID voice/filter pipeline scheduler.
package sid_pipe_sched_pkg;

  localparam int unsigned FILTER_STAGES = 8;
  localparam int unsigned VOICE_LAT     = 1;

  typedef enum logic {VIdle, VIssue} v_state_e;

  typedef enum logic [1:0] {FIdle, FRun, FDone} f_state_e;

  // SID fields sized for the largest supported configuration (4 cores).
  typedef struct packed {
    logic       v_issue;
    logic [1:0] v_sid;
    logic [1:0] v_no;
    logic       v_cap;
    logic [1:0] v_cap_sid;
    logic [1:0] v_cap_no;
    logic       f_load;
    logic [1:0] f_sid;
    logic [2:0] f_stage;
    logic       f_active;
    logic       f_done;
    logic [1:0] f_done_sid;
  } pipe_sched_o_t;

  function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lowest_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/sid_pipe_sched_filter_arb.sv
// Filter pipeline arbiter: pending mask, lowest-index grant, stage counter and
// per-SID / per-frame completion strobes.
module sid_filter_arb #(
  parameter int unsigned NSID          = 2,
  parameter int unsigned FILTER_STAGES = 8,
  parameter int unsigned SIDW          = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSID-1:0] req_i,
  output logic            f_load_o,
  output logic [SIDW-1:0] f_sid_o,
  output logic [2:0]      f_stage_o,
  output logic            f_active_o,
  output logic            f_done_o,
  output logic [SIDW-1:0] f_done_sid_o,
  output logic            frame_done_o
);
  import sid_pipe_sched_pkg::*;

  f_state_e        state_q, state_d;
  logic [SIDW-1:0] sid_q, sid_d;
  logic [2:0]      stage_q, stage_d;
  logic [NSID-1:0] pend_q, pend_d, gmask;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      gidx;
  logic            grant;

  always_comb begin
    state_d      = state_q;
    sid_d        = sid_q;
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    grant        = 1'b0;
    f_load_o     = 1'b0;
    f_sid_o      = '0;
    f_stage_o    = 3'd0;
    f_active_o   = 1'b0;
    f_done_o     = 1'b0;
    f_done_sid_o = '0;
    frame_done_o = 1'b0;
    gidx         = lowest_idx(4'(pend_q));

    unique case (state_q)
      FRun: begin
        f_active_o = 1'b1;
        f_sid_o    = sid_q;
        f_stage_o  = stage_q;
        if (stage_q == 3'(FILTER_STAGES - 1)) state_d = FDone;
        else                                   stage_d = stage_q + 3'd1;
      end
      FDone: begin
        f_done_o     = 1'b1;
        f_done_sid_o = sid_q;
        state_d      = FIdle;
        if (cnt_q == 2'(NSID - 1)) begin
          frame_done_o = 1'b1;
          cnt_d        = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
        grant = |pend_q;
      end
      default: grant = |pend_q;
    endcase

    // A grant overrides the idle/done outputs so filter slots run back-to-back.
    if (grant) begin
      f_load_o   = 1'b1;
      f_active_o = 1'b1;
      f_stage_o  = 3'd0;
      f_sid_o    = gidx[SIDW-1:0];
      sid_d      = gidx[SIDW-1:0];
      if (FILTER_STAGES == 1) begin
        state_d = FDone;
      end else begin
        state_d = FRun;
        stage_d = 3'd1;
      end
    end

    for (int k = 0; k < NSID; k++) gmask[k] = grant && (gidx == 2'(k));
    pend_d = (pend_q & ~gmask) | req_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FIdle;
      sid_q   <= '0;
      stage_q <= 3'd0;
      pend_q  <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sid_q   <= sid_d;
      stage_q <= stage_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sid_pipe_sched.sv
// Central scheduler for the shared voice and filter pipelines: voice issue FSM,
// capture delay line, and the filter arbiter.
module sid_pipe_sched #(
  parameter int unsigned NSID          = 2,
  parameter int unsigned NVOICE        = 3,
  parameter int unsigned VOICE_LAT     = sid_pipe_sched_pkg::VOICE_LAT,
  parameter int unsigned FILTER_STAGES = sid_pipe_sched_pkg::FILTER_STAGES,
  parameter int unsigned SIDW          = (NSID > 1) ? $clog2(NSID) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            overrun_clr_i,
  output logic            busy_o,
  output logic            v_issue_o,
  output logic [SIDW-1:0] v_sid_o,
  output logic [1:0]      v_no_o,
  output logic            v_cap_o,
  output logic [SIDW-1:0] v_cap_sid_o,
  output logic [1:0]      v_cap_no_o,
  output logic            f_load_o,
  output logic [SIDW-1:0] f_sid_o,
  output logic [2:0]      f_stage_o,
  output logic            f_active_o,
  output logic            f_done_o,
  output logic [SIDW-1:0] f_done_sid_o,
  output logic            frame_done_o,
  output logic            overrun_o
);
  import sid_pipe_sched_pkg::*;

  v_state_e        vst_q, vst_d;
  logic [SIDW-1:0] vsid_q, vsid_d;
  logic [1:0]      vno_q, vno_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic            accept, frame_done;
  logic [NSID-1:0] req;

  logic [VOICE_LAT-1:0] cap_v_q;
  logic [SIDW-1:0]      cap_sid_q [VOICE_LAT];
  logic [1:0]           cap_no_q  [VOICE_LAT];

  assign accept = start_i && !busy_q;

  always_comb begin
    vst_d  = vst_q;
    vsid_d = vsid_q;
    vno_d  = vno_q;
    busy_d = busy_q;
    ovr_d  = ovr_q;

    unique case (vst_q)
      VIssue: begin
        if (vno_q == 2'(NVOICE - 1)) begin
          vno_d = 2'd0;
          // Explicit return to zero: SID field need not be a power of two.
          if (vsid_q == SIDW'(NSID - 1)) begin
            vsid_d = '0;
            vst_d  = VIdle;
          end else begin
            vsid_d = vsid_q + SIDW'(1);
          end
        end else begin
          vno_d = vno_q + 2'd1;
        end
      end
      default: if (accept) vst_d = VIssue;
    endcase

    if (accept)          busy_d = 1'b1;
    else if (frame_done) busy_d = 1'b0;

    if (overrun_clr_i)         ovr_d = 1'b0;
    if (start_i && busy_q)     ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vst_q  <= VIdle;
      vsid_q <= '0;
      vno_q  <= 2'd0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      for (int i = 0; i < VOICE_LAT; i++) begin
        cap_v_q[i]   <= 1'b0;
        cap_sid_q[i] <= '0;
        cap_no_q[i]  <= 2'd0;
      end
    end else begin
      vst_q  <= vst_d;
      vsid_q <= vsid_d;
      vno_q  <= vno_d;
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
      cap_v_q[0]   <= v_issue_o;
      cap_sid_q[0] <= v_sid_o;
      cap_no_q[0]  <= v_no_o;
      for (int i = 1; i < VOICE_LAT; i++) begin
        cap_v_q[i]   <= cap_v_q[i-1];
        cap_sid_q[i] <= cap_sid_q[i-1];
        cap_no_q[i]  <= cap_no_q[i-1];
      end
    end
  end

  assign v_issue_o   = (vst_q == VIssue);
  assign v_sid_o     = vsid_q;
  assign v_no_o      = vno_q;
  assign v_cap_o     = cap_v_q[VOICE_LAT-1];
  assign v_cap_sid_o = cap_sid_q[VOICE_LAT-1];
  assign v_cap_no_o  = cap_no_q[VOICE_LAT-1];
  assign busy_o      = busy_q;
  assign overrun_o   = ovr_q;
  assign frame_done_o = frame_done;

  // Last voice of a core leaving the voice pipeline raises its filter request.
  always_comb begin
    for (int k = 0; k < NSID; k++) begin
      req[k] = v_cap_o && (v_cap_no_o == 2'(NVOICE - 1)) && (v_cap_sid_o == SIDW'(k));
    end
  end

  sid_filter_arb #(
    .NSID          (NSID),
    .FILTER_STAGES (FILTER_STAGES),
    .SIDW          (SIDW)
  ) u_arb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req),
    .f_load_o     (f_load_o),
    .f_sid_o      (f_sid_o),
    .f_stage_o    (f_stage_o),
    .f_active_o   (f_active_o),
    .f_done_o     (f_done_o),
    .f_done_sid_o (f_done_sid_o),
    .frame_done_o (frame_done)
  );

endmodule

// File: tb/tb_sid_pipe_sched.sv
// Directed bench for sid_pipe_sched: default, single-core long-latency and
// four-core configurations.
module tb_sid_pipe_sched;
  import sid_pipe_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default configuration (NSID=2, NVOICE=3, VOICE_LAT=1)
  logic       a_start = 1'b0, a_clr = 1'b0;
  logic       a_busy, a_viss, a_vcap, a_fload, a_fact, a_fdone, a_frdone, a_ovr;
  logic [0:0] a_vsid, a_csid, a_fsid, a_dsid;
  logic [1:0] a_vno, a_cno;
  logic [2:0] a_fstg;

  // NSID=1, VOICE_LAT=3
  logic       b_start = 1'b0;
  logic       b_busy, b_viss, b_vcap, b_fload, b_fact, b_fdone, b_frdone, b_ovr;
  logic [0:0] b_vsid, b_csid, b_fsid, b_dsid;
  logic [1:0] b_vno, b_cno;
  logic [2:0] b_fstg;

  // NSID=4
  logic       c_start = 1'b0;
  logic       c_busy, c_viss, c_vcap, c_fload, c_fact, c_fdone, c_frdone, c_ovr;
  logic [1:0] c_vsid, c_csid, c_fsid, c_dsid;
  logic [1:0] c_vno, c_cno;
  logic [2:0] c_fstg;

  sid_pipe_sched u_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .overrun_clr_i(a_clr), .busy_o(a_busy),
    .v_issue_o(a_viss), .v_sid_o(a_vsid), .v_no_o(a_vno), .v_cap_o(a_vcap),
    .v_cap_sid_o(a_csid), .v_cap_no_o(a_cno), .f_load_o(a_fload), .f_sid_o(a_fsid),
    .f_stage_o(a_fstg), .f_active_o(a_fact), .f_done_o(a_fdone), .f_done_sid_o(a_dsid),
    .frame_done_o(a_frdone), .overrun_o(a_ovr)
  );

  sid_pipe_sched #(.NSID(1), .VOICE_LAT(3)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .overrun_clr_i(1'b0), .busy_o(b_busy),
    .v_issue_o(b_viss), .v_sid_o(b_vsid), .v_no_o(b_vno), .v_cap_o(b_vcap),
    .v_cap_sid_o(b_csid), .v_cap_no_o(b_cno), .f_load_o(b_fload), .f_sid_o(b_fsid),
    .f_stage_o(b_fstg), .f_active_o(b_fact), .f_done_o(b_fdone), .f_done_sid_o(b_dsid),
    .frame_done_o(b_frdone), .overrun_o(b_ovr)
  );

  sid_pipe_sched #(.NSID(4)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(c_start), .overrun_clr_i(1'b0), .busy_o(c_busy),
    .v_issue_o(c_viss), .v_sid_o(c_vsid), .v_no_o(c_vno), .v_cap_o(c_vcap),
    .v_cap_sid_o(c_csid), .v_cap_no_o(c_cno), .f_load_o(c_fload), .f_sid_o(c_fsid),
    .f_stage_o(c_fstg), .f_active_o(c_fact), .f_done_o(c_fdone), .f_done_sid_o(c_dsid),
    .frame_done_o(c_frdone), .overrun_o(c_ovr)
  );

  typedef struct {
    int            cyc;
    logic          start;
    logic          clr;
    pipe_sched_o_t exp;
    logic          frame_done;
    logic          busy;
    logic          ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int cyc, logic st, logic cl,
                              logic iss, int vsid, int vno, logic cap, int csid, int cno,
                              logic load, int fsid, int stg, logic act, logic done, int dsid,
                              logic fd, logic busy, logic ovr);
    vec_t v;
    v.cyc = cyc; v.start = st; v.clr = cl;
    v.exp.v_issue = iss;  v.exp.v_sid = 2'(vsid);     v.exp.v_no = 2'(vno);
    v.exp.v_cap = cap;    v.exp.v_cap_sid = 2'(csid); v.exp.v_cap_no = 2'(cno);
    v.exp.f_load = load;  v.exp.f_sid = 2'(fsid);     v.exp.f_stage = 3'(stg);
    v.exp.f_active = act; v.exp.f_done = done;        v.exp.f_done_sid = 2'(dsid);
    v.frame_done = fd; v.busy = busy; v.ovr = ovr;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_a(input vec_t e);
    pipe_sched_o_t g;
    g.v_issue = a_viss;  g.v_sid = 2'(a_vsid);     g.v_no = a_vno;
    g.v_cap = a_vcap;    g.v_cap_sid = 2'(a_csid); g.v_cap_no = a_cno;
    g.f_load = a_fload;  g.f_sid = 2'(a_fsid);     g.f_stage = a_fstg;
    g.f_active = a_fact; g.f_done = a_fdone;       g.f_done_sid = 2'(a_dsid);
    chk("v_issue",    e.cyc, 8'(g.v_issue),    8'(e.exp.v_issue));
    chk("v_sid",      e.cyc, 8'(g.v_sid),      8'(e.exp.v_sid));
    chk("v_no",       e.cyc, 8'(g.v_no),       8'(e.exp.v_no));
    chk("v_cap",      e.cyc, 8'(g.v_cap),      8'(e.exp.v_cap));
    chk("v_cap_sid",  e.cyc, 8'(g.v_cap_sid),  8'(e.exp.v_cap_sid));
    chk("v_cap_no",   e.cyc, 8'(g.v_cap_no),   8'(e.exp.v_cap_no));
    chk("f_load",     e.cyc, 8'(g.f_load),     8'(e.exp.f_load));
    chk("f_sid",      e.cyc, 8'(g.f_sid),      8'(e.exp.f_sid));
    chk("f_stage",    e.cyc, 8'(g.f_stage),    8'(e.exp.f_stage));
    chk("f_active",   e.cyc, 8'(g.f_active),   8'(e.exp.f_active));
    chk("f_done",     e.cyc, 8'(g.f_done),     8'(e.exp.f_done));
    chk("f_done_sid", e.cyc, 8'(g.f_done_sid), 8'(e.exp.f_done_sid));
    chk("frame_done", e.cyc, 8'(a_frdone),     8'(e.frame_done));
    chk("busy",       e.cyc, 8'(a_busy),       8'(e.busy));
    chk("overrun",    e.cyc, 8'(a_ovr),        8'(e.ovr));
  endtask

  initial begin
    int idx;
    int s;
    //                cyc st cl iss vs vn cap cs cn ld fs stg act dn ds fd by ov
    tbl.push_back(mk( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 2, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 3, 0, 0, 1, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 4, 0, 0, 1, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 5, 0, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 6, 0, 0, 1, 1, 2, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 7, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 2, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(21, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(22, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(23, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(25, 1, 1, 1, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(26, 0, 0, 1, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(27, 0, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(35, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(43, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(50, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(51, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_a(mk(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 58; c++) begin
      idx = -1;
      foreach (tbl[i]) if (tbl[i].cyc == c) idx = i;
      a_start = (idx >= 0) ? tbl[idx].start : 1'b0;
      a_clr   = (idx >= 0) ? tbl[idx].clr : 1'b0;
      b_start = (c == 0);
      c_start = (c == 0);
      @(negedge clk);
      if (idx >= 0) check_a(tbl[idx]);
      if (c <= 40) begin
        chk("b_v_issue",    c, 8'(b_viss),   8'(c >= 1 && c <= 3));
        chk("b_v_cap",      c, 8'(b_vcap),   8'(c >= 4 && c <= 6));
        chk("b_f_load",     c, 8'(b_fload),  8'(c == 7));
        chk("b_f_done",     c, 8'(b_fdone),  8'(c == 15));
        chk("b_frame_done", c, 8'(b_frdone), 8'(c == 15));
        chk("b_busy",       c, 8'(b_busy),   8'(c >= 1 && c <= 15));
        chk("c_f_load",     c, 8'(c_fload),  8'(c == 5 || c == 13 || c == 21 || c == 29));
        if (c_fload) chk("c_f_sid", c, 8'(c_fsid), 8'((c - 5) / 8));
        chk("c_f_active",   c, 8'(c_fact),   8'(c >= 5 && c <= 36));
        chk("c_f_done",     c, 8'(c_fdone),  8'(c == 13 || c == 21 || c == 29 || c == 37));
        chk("c_frame_done", c, 8'(c_frdone), 8'(c == 37));
      end
      @(posedge clk);
      #1;
    end
    a_start = 1'b0;
    a_clr   = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;

    // Reset mid-frame (cycle 8 of the frame started at 50): outputs clear without a clock edge.
    #1 rst = 1'b1;
    #1 check_a(mk(58, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rst_f_done",     59 + k, 8'(a_fdone),  8'd0);
      chk("rst_frame_done", 59 + k, 8'(a_frdone), 8'd0);
      chk("rst_f_active",   59 + k, 8'(a_fact),   8'd0);
      @(posedge clk);
      #1;
    end

    s = 69;
    a_start = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("post_rst_v_issue", s + k, 8'(a_viss), 8'd1);
        chk("post_rst_v_sid",   s + k, 8'(a_vsid), 8'd0);
      end
      if (k == 5) begin
        chk("post_rst_f_load", s + k, 8'(a_fload), 8'd1);
        chk("post_rst_f_sid",  s + k, 8'(a_fsid),  8'd0);
      end
      if (k == 13) chk("post_rst_f_sid1", s + k, 8'(a_fsid), 8'd1);
      chk("post_rst_frame_done", s + k, 8'(a_frdone), 8'(k == 21));
      chk("post_rst_busy",       s + k, 8'(a_busy),   8'(k >= 1 && k <= 21));
      @(posedge clk);
      #1 a_start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
